// File: rtl/scr1_tcm_arb_pkg.sv
// ----------------------------------------------------------------------------
// scr1_tcm_arb_pkg
// Shared types and helpers for the TCM port B arbiter.
//   type_tcm_cmd_e    : READ / WRITE command encoding
//   type_tcm_width_e  : BYTE / HALF / WORD access width (2'd3 is illegal)
//   type_tcm_owner_e  : owner of the response that is due next cycle
//   tcm_misaligned()  : misalignment check for a legal width
// ----------------------------------------------------------------------------
package scr1_tcm_arb_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } type_tcm_cmd_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } type_tcm_width_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DM   = 2'd1,
    SB   = 2'd2
  } type_tcm_owner_e;

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic tcm_misaligned(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    return ((width == HALF) && addr_lo[0]) ||
           ((width == WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/scr1_tcm_portb_arb_if.sv
// ----------------------------------------------------------------------------
// Interfaces of the TCM port B arbiter.
//
// scr1_tcm_req_if : one requester (DMEM or SBA).
//   Handshake: the requester raises req with cmd/width/addr/wdata and holds
//   them stable until it sees ack in the same cycle (ack is a same-cycle
//   "accepted" strobe, like ready with req as valid). Exactly one cycle after
//   ack, resp pulses for one cycle; err qualifies resp, rdata is the raw
//   memory word for a successful read and 0 otherwise.
//   modport master : the requester side
//   modport slave  : the arbiter side
//
// scr1_tcm_mem_if : port B of the TCM memory.
//   renb/wenb strobes, webb byte enables, addrb word address, datab write
//   data; qb is read data valid the cycle after renb.
//   modport master : the arbiter side
//   modport slave  : the memory side
// ----------------------------------------------------------------------------
interface scr1_tcm_req_if #(
  parameter int AW = 16
);
  logic          req;
  logic          cmd;
  logic [1:0]    width;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ack;
  logic          resp;
  logic          err;
  logic [31:0]   rdata;

  modport master (output req, cmd, width, addr, wdata,
                  input  ack, resp, err, rdata);
  modport slave  (input  req, cmd, width, addr, wdata,
                  output ack, resp, err, rdata);
endinterface

interface scr1_tcm_mem_if #(
  parameter int AW = 16
);
  logic          renb;
  logic          wenb;
  logic [3:0]    webb;
  logic [AW-3:0] addrb;
  logic [31:0]   datab;
  logic [31:0]   qb;

  modport master (output renb, wenb, webb, addrb, datab,
                  input  qb);
  modport slave  (input  renb, wenb, webb, addrb, datab,
                  output qb);
endinterface

// File: rtl/scr1_tcm_lane_fmt.sv
// ----------------------------------------------------------------------------
// scr1_tcm_lane_fmt
// Purely combinational byte-lane formatter for one access.
//   i_width     : access width (BYTE/HALF/WORD, 3 illegal)
//   i_addr_lo   : byte offset within the word
//   i_wdata     : right-justified write data
//   o_webb      : byte enables for the addressed lanes
//   o_datab     : write data shifted onto its lanes, unused lanes zero
//   o_illegal   : width 3 or misaligned access
// ----------------------------------------------------------------------------
module scr1_tcm_lane_fmt
  import scr1_tcm_arb_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_webb,
  output logic [31:0] o_datab,
  output logic        o_illegal
);

  logic [4:0] w_shamt;

  assign w_shamt = {i_addr_lo, 3'b000};

  always_comb begin
    o_webb    = 4'b0000;
    o_datab   = 32'h0;
    o_illegal = 1'b0;
    case (i_width)
      BYTE: begin
        o_webb  = 4'b0001 << i_addr_lo;
        o_datab = {24'h0, i_wdata[7:0]} << w_shamt;
      end
      HALF: begin
        o_webb  = 4'b0011 << i_addr_lo;
        o_datab = {16'h0, i_wdata[15:0]} << w_shamt;
      end
      WORD: begin
        o_webb  = 4'b1111;
        o_datab = i_wdata;
      end
      default: o_illegal = 1'b1;
    endcase
    if (tcm_misaligned(i_width, i_addr_lo)) begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/scr1_tcm_portb_arb.sv
// ----------------------------------------------------------------------------
// scr1_tcm_portb_arb
// Shares TCM port B between the core data interface (DMEM) and the system
// bus access requester (SBA). One access is accepted per cycle; its response
// returns exactly one cycle later to the requester that won.
//   clk, rst          : clock, synchronous active-high reset
//   dm_if             : DMEM requester (slave modport)
//   sb_if             : SBA requester (slave modport)
//   mem_if            : memory port B (master modport)
//   o_dbg_starve_cnt  : consecutive DMEM wins while SBA waits
//   o_dbg_resp_owner  : owner of the response driven this cycle
// ----------------------------------------------------------------------------
module scr1_tcm_portb_arb
  import scr1_tcm_arb_pkg::*;
#(
  parameter int SCR1_SIZE    = 65536,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(SCR1_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  scr1_tcm_req_if.slave   dm_if,
  scr1_tcm_req_if.slave   sb_if,
  scr1_tcm_mem_if.master  mem_if,
  output logic [3:0]      o_dbg_starve_cnt,
  output type_tcm_owner_e o_dbg_resp_owner
);

  localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);

  logic            w_dm_win;
  logic            w_sb_win;
  logic            w_dm_ack;
  logic            w_sb_ack;
  logic            w_grant;
  logic            w_cmd;
  logic [1:0]      w_width;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_fmt_webb;
  logic [31:0]     w_fmt_datab;
  logic            w_fmt_illegal;
  logic            w_rd;
  logic            w_wr;
  logic            w_dm_resp;
  logic            w_sb_resp;
  logic [3:0]      w_starve_nxt;
  type_tcm_owner_e w_owner_nxt;

  logic [3:0]      r_starve_cnt;
  type_tcm_owner_e r_resp_owner;
  logic            r_resp_is_read;
  logic            r_resp_err;

  // Arbitration and winner mux. DMEM has priority until SBA has been passed
  // over STARVE_LIMIT times in a row. Acks are forced low during reset.
  always_comb begin
    w_dm_win = dm_if.req & (~sb_if.req | (r_starve_cnt != LIMIT4));
    w_sb_win = sb_if.req & ~w_dm_win;
    w_dm_ack = w_dm_win & ~rst;
    w_sb_ack = w_sb_win & ~rst;
    w_grant  = w_dm_ack | w_sb_ack;

    w_cmd    = dm_if.cmd;
    w_width  = dm_if.width;
    w_addr   = dm_if.addr;
    w_wdata  = dm_if.wdata;
    if (w_sb_win) begin
      w_cmd   = sb_if.cmd;
      w_width = sb_if.width;
      w_addr  = sb_if.addr;
      w_wdata = sb_if.wdata;
    end
  end

  scr1_tcm_lane_fmt u_lane_fmt (
    .i_width   (w_width),
    .i_addr_lo (w_addr[1:0]),
    .i_wdata   (w_wdata),
    .o_webb    (w_fmt_webb),
    .o_datab   (w_fmt_datab),
    .o_illegal (w_fmt_illegal)
  );

  // Rejected accesses are still acked but never reach the memory.
  assign w_rd = w_grant & ~w_fmt_illegal & (w_cmd == READ);
  assign w_wr = w_grant & ~w_fmt_illegal & (w_cmd == WRITE);

  assign mem_if.renb  = w_rd;
  assign mem_if.wenb  = w_wr;
  assign mem_if.webb  = w_wr ? w_fmt_webb : 4'b0000;
  assign mem_if.addrb = w_grant ? w_addr[AW-1:2] : '0;
  assign mem_if.datab = w_wr ? w_fmt_datab : 32'h0;

  // Next-state for the starvation counter and the response owner.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    w_owner_nxt  = NONE;
    if (!sb_if.req || w_sb_ack) begin
      w_starve_nxt = 4'd0;
    end else if (w_dm_ack && (r_starve_cnt != LIMIT4)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
    if (w_dm_ack) begin
      w_owner_nxt = DM;
    end else if (w_sb_ack) begin
      w_owner_nxt = SB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt   <= 4'd0;
      r_resp_owner   <= NONE;
      r_resp_is_read <= 1'b0;
      r_resp_err     <= 1'b0;
    end else begin
      r_starve_cnt   <= w_starve_nxt;
      r_resp_owner   <= w_owner_nxt;
      r_resp_is_read <= w_rd;
      r_resp_err     <= w_grant & w_fmt_illegal;
    end
  end

  // A response owed while reset is high is dropped, not deferred.
  assign w_dm_resp = (r_resp_owner == DM) & ~rst;
  assign w_sb_resp = (r_resp_owner == SB) & ~rst;

  assign dm_if.ack   = w_dm_ack;
  assign dm_if.resp  = w_dm_resp;
  assign dm_if.err   = w_dm_resp & r_resp_err;
  assign dm_if.rdata = (w_dm_resp & r_resp_is_read) ? mem_if.qb : 32'h0;

  assign sb_if.ack   = w_sb_ack;
  assign sb_if.resp  = w_sb_resp;
  assign sb_if.err   = w_sb_resp & r_resp_err;
  assign sb_if.rdata = (w_sb_resp & r_resp_is_read) ? mem_if.qb : 32'h0;

  assign o_dbg_starve_cnt = r_starve_cnt;
  assign o_dbg_resp_owner = r_resp_owner;

endmodule

// File: tb/tb_scr1_tcm_portb_arb.sv
// ----------------------------------------------------------------------------
// tb_scr1_tcm_portb_arb
// Directed bench for scr1_tcm_portb_arb with a behavioural port B memory.
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
// ----------------------------------------------------------------------------
module tb_scr1_tcm_portb_arb;
  import scr1_tcm_arb_pkg::*;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0]      dbg_starve;
  type_tcm_owner_e dbg_owner;

  scr1_tcm_req_if #(.AW(AW)) dm_if ();
  scr1_tcm_req_if #(.AW(AW)) sb_if ();
  scr1_tcm_mem_if #(.AW(AW)) mem_if ();

  scr1_tcm_portb_arb #(
    .SCR1_SIZE    (65536),
    .STARVE_LIMIT (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dm_if            (dm_if),
    .sb_if            (sb_if),
    .mem_if           (mem_if),
    .o_dbg_starve_cnt (dbg_starve),
    .o_dbg_resp_owner (dbg_owner)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- port B memory model ----------------
  logic [31:0] ram [0:16383];

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
  end

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_if.wenb && mem_if.webb[b]) ram[mem_if.addrb][8*b +: 8] <= mem_if.datab[8*b +: 8];
    end
    if (mem_if.renb) mem_if.qb <= ram[mem_if.addrb];
  end

  // ---------------- driver tasks ----------------
  task automatic dm_drv(input logic req, input logic cmd, input logic [1:0] w,
                        input logic [AW-1:0] a, input logic [31:0] d);
    dm_if.req = req; dm_if.cmd = cmd; dm_if.width = w; dm_if.addr = a; dm_if.wdata = d;
  endtask

  task automatic sb_drv(input logic req, input logic cmd, input logic [1:0] w,
                        input logic [AW-1:0] a, input logic [31:0] d);
    sb_if.req = req; sb_if.cmd = cmd; sb_if.width = w; sb_if.addr = a; sb_if.wdata = d;
  endtask

  task automatic idle();
    dm_drv(1'b0, 1'b0, 2'd0, '0, 32'h0);
    sb_drv(1'b0, 1'b0, 2'd0, '0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic exp_sb;
    logic prev_sb;
    idle();

    // Reset: request held during reset must not be acked.
    step();
    dm_drv(1'b1, READ, WORD, 16'h0100, 32'h0);
    @(negedge clk);
    chk("rst_dm_ack", dm_if.ack, 0);
    chk("rst_renb", mem_if.renb, 0);
    chk("rst_addrb", mem_if.addrb, 0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_dm_resp", dm_if.resp, 0);
    chk("post_rst_sb_resp", sb_if.resp, 0);
    chk("post_rst_starve", dbg_starve, 0);
    chk("post_rst_owner", dbg_owner, NONE);

    // DMEM word write then word read at 0x100.
    step();
    dm_drv(1'b1, WRITE, WORD, 16'h0100, 32'hDEADBEEF);
    @(negedge clk);
    chk("dmw_ack", dm_if.ack, 1);
    chk("dmw_sb_ack", sb_if.ack, 0);
    chk("dmw_wenb", mem_if.wenb, 1);
    chk("dmw_renb", mem_if.renb, 0);
    chk("dmw_webb", mem_if.webb, 4'hF);
    chk("dmw_addrb", mem_if.addrb, 14'h040);
    chk("dmw_datab", mem_if.datab, 32'hDEADBEEF);
    step();
    dm_drv(1'b1, READ, WORD, 16'h0100, 32'h0);
    @(negedge clk);
    chk("dmw_resp", dm_if.resp, 1);
    chk("dmw_err", dm_if.err, 0);
    chk("dmw_rdata", dm_if.rdata, 0);
    chk("dmr_ack", dm_if.ack, 1);
    chk("dmr_renb", mem_if.renb, 1);
    chk("dmr_webb", mem_if.webb, 0);
    chk("dmr_addrb", mem_if.addrb, 14'h040);
    step();
    idle();
    @(negedge clk);
    chk("dmr_resp", dm_if.resp, 1);
    chk("dmr_err", dm_if.err, 0);
    chk("dmr_rdata", dm_if.rdata, 32'hDEADBEEF);
    chk("dmr_sb_resp", sb_if.resp, 0);

    // SBA byte write 0xA5 at 0x103, then word read of 0x100.
    step();
    sb_drv(1'b1, WRITE, BYTE, 16'h0103, 32'h000000A5);
    @(negedge clk);
    chk("sbb_ack", sb_if.ack, 1);
    chk("sbb_dm_ack", dm_if.ack, 0);
    chk("sbb_wenb", mem_if.wenb, 1);
    chk("sbb_webb", mem_if.webb, 4'b1000);
    chk("sbb_datab", mem_if.datab, 32'hA5000000);
    step();
    sb_drv(1'b1, READ, WORD, 16'h0100, 32'h0);
    @(negedge clk);
    chk("sbb_resp", sb_if.resp, 1);
    chk("sbb_dm_resp", dm_if.resp, 0);
    chk("sbr_renb", mem_if.renb, 1);
    step();
    sb_drv(1'b1, WRITE, WORD, 16'h0200, 32'h11223344);
    @(negedge clk);
    chk("sbr_resp", sb_if.resp, 1);
    chk("sbr_rdata", sb_if.rdata, 32'hA5ADBEEF);
    chk("sbw2_webb", mem_if.webb, 4'hF);
    chk("sbw2_addrb", mem_if.addrb, 14'h080);
    // Half write at the upper half: only the low 16 bits of wdata are used.
    step();
    sb_drv(1'b1, WRITE, HALF, 16'h0102, 32'h1234CAFE);
    @(negedge clk);
    chk("sbh_prev_rdata", sb_if.rdata, 0);
    chk("sbh_webb", mem_if.webb, 4'b1100);
    chk("sbh_datab", mem_if.datab, 32'hCAFE0000);
    step();
    idle();
    @(negedge clk);
    chk("sbh_resp", sb_if.resp, 1);
    chk("sbh_err", sb_if.err, 0);

    // Rejected accesses: misaligned half, misaligned word, width 3.
    step();
    dm_drv(1'b1, WRITE, HALF, 16'h0101, 32'h00001234);
    @(negedge clk);
    chk("mish_ack", dm_if.ack, 1);
    chk("mish_wenb", mem_if.wenb, 0);
    chk("mish_renb", mem_if.renb, 0);
    chk("mish_webb", mem_if.webb, 0);
    step();
    dm_drv(1'b0, READ, WORD, '0, 32'h0);
    sb_drv(1'b1, READ, WORD, 16'h0102, 32'h0);
    @(negedge clk);
    chk("mish_resp", dm_if.resp, 1);
    chk("mish_err", dm_if.err, 1);
    chk("mish_rdata", dm_if.rdata, 0);
    chk("misw_ack", sb_if.ack, 1);
    chk("misw_renb", mem_if.renb, 0);
    step();
    sb_drv(1'b0, READ, WORD, '0, 32'h0);
    dm_drv(1'b1, READ, 2'd3, 16'h0100, 32'h0);
    @(negedge clk);
    chk("misw_resp", sb_if.resp, 1);
    chk("misw_err", sb_if.err, 1);
    chk("misw_rdata", sb_if.rdata, 0);
    chk("w3_ack", dm_if.ack, 1);
    chk("w3_renb", mem_if.renb, 0);
    chk("w3_wenb", mem_if.wenb, 0);
    step();
    idle();
    @(negedge clk);
    chk("w3_resp", dm_if.resp, 1);
    chk("w3_err", dm_if.err, 1);
    chk("w3_rdata", dm_if.rdata, 0);

    // Both requesting continuously: DM x4, SB, repeating.
    step();
    dm_drv(1'b1, READ, WORD, 16'h0100, 32'h0);
    sb_drv(1'b1, READ, WORD, 16'h0200, 32'h0);
    prev_sb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_sb = ((i % 5) == 4);
      @(negedge clk);
      chk($sformatf("stv%0d_dm_ack", i), dm_if.ack, !exp_sb);
      chk($sformatf("stv%0d_sb_ack", i), sb_if.ack, exp_sb);
      chk($sformatf("stv%0d_cnt", i), dbg_starve, i % 5);
      if (i > 0) begin
        chk($sformatf("stv%0d_dm_resp", i), dm_if.resp, !prev_sb);
        chk($sformatf("stv%0d_sb_resp", i), sb_if.resp, prev_sb);
      end
      prev_sb = exp_sb;
      step();
    end
    idle();
    @(negedge clk);
    chk("stv_last_sb_resp", sb_if.resp, 1);
    chk("stv_last_sb_rdata", sb_if.rdata, 32'h11223344);
    chk("stv_last_dm_resp", dm_if.resp, 0);

    // Alternating single DM / SB reads every cycle.
    for (int i = 0; i < 6; i++) begin
      step();
      if ((i % 2) == 0) begin
        sb_drv(1'b0, READ, WORD, '0, 32'h0);
        dm_drv(1'b1, READ, WORD, 16'h0100, 32'h0);
      end else begin
        dm_drv(1'b0, READ, WORD, '0, 32'h0);
        sb_drv(1'b1, READ, WORD, 16'h0200, 32'h0);
      end
      @(negedge clk);
      chk($sformatf("alt%0d_ack", i), ((i % 2) == 0) ? dm_if.ack : sb_if.ack, 1);
      if (i > 0) begin
        if ((i % 2) == 0) begin
          chk($sformatf("alt%0d_sb_resp", i), sb_if.resp, 1);
          chk($sformatf("alt%0d_sb_rdata", i), sb_if.rdata, 32'h11223344);
          chk($sformatf("alt%0d_dm_resp", i), dm_if.resp, 0);
        end else begin
          chk($sformatf("alt%0d_dm_resp", i), dm_if.resp, 1);
          chk($sformatf("alt%0d_dm_rdata", i), dm_if.rdata, 32'hCAFEBEEF);
          chk($sformatf("alt%0d_sb_resp", i), sb_if.resp, 0);
        end
      end
    end
    step();
    idle();
    @(negedge clk);
    chk("alt_last_sb_resp", sb_if.resp, 1);
    chk("alt_last_sb_rdata", sb_if.rdata, 32'h11223344);

    // Reset in the cycle after a read ack, with the starve counter non-zero.
    step();
    dm_drv(1'b1, READ, WORD, 16'h0100, 32'h0);
    sb_drv(1'b1, READ, WORD, 16'h0200, 32'h0);
    @(negedge clk);
    chk("rr_cnt0", dbg_starve, 0);
    chk("rr_ack0", dm_if.ack, 1);
    step();
    @(negedge clk);
    chk("rr_cnt1", dbg_starve, 1);
    chk("rr_ack1", dm_if.ack, 1);
    chk("rr_renb1", mem_if.renb, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rr_dm_resp", dm_if.resp, 0);
    chk("rr_sb_resp", sb_if.resp, 0);
    chk("rr_dm_rdata", dm_if.rdata, 0);
    chk("rr_dm_err", dm_if.err, 0);
    chk("rr_dm_ack", dm_if.ack, 0);
    chk("rr_sb_ack", sb_if.ack, 0);
    chk("rr_renb", mem_if.renb, 0);
    chk("rr_wenb", mem_if.wenb, 0);
    chk("rr_webb", mem_if.webb, 0);
    chk("rr_addrb", mem_if.addrb, 0);
    chk("rr_datab", mem_if.datab, 0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rr_post_cnt", dbg_starve, 0);
    chk("rr_post_owner", dbg_owner, NONE);
    chk("rr_post_dm_resp", dm_if.resp, 0);
    step();
    dm_drv(1'b1, READ, WORD, 16'h0100, 32'h0);
    @(negedge clk);
    chk("rr_new_ack", dm_if.ack, 1);
    chk("rr_new_renb", mem_if.renb, 1);
    step();
    idle();
    @(negedge clk);
    chk("rr_new_resp", dm_if.resp, 1);
    chk("rr_new_err", dm_if.err, 0);
    chk("rr_new_rdata", dm_if.rdata, 32'hCAFEBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
